// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// The PARITY code is always reserved; it is only reachable with NIBBLE_TX_PARITY_EN.
package nibble_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;

    // Counter width that never collapses to zero bits for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_tx_tick.sv
// Bit-period timer: pulses bit_end on the last cycle of each serial bit.
// It is held at zero whenever en is low, so every frame starts on a clean bit boundary.
module bit_tick_gen
    import nibble_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic en,
    output logic bit_end
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // When CLKS_PER_BIT is 1, CNT_TOP is 0 and the counter never leaves 0.
    assign bit_end = en && (cnt == CNT_TOP);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            cnt <= '0;
        else if (!en || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// Serial framer: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Defining NIBBLE_TX_PARITY_EN inserts the parity bit between the data bits and the stop bit.
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Ce,
    input  logic [DATA_W-1:0] Din,
    output logic              Rdy,
    output logic              Txd,
    output logic              Busy
);

    localparam int BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bidx;
    logic              bit_end;
    logic              accept;
`ifdef NIBBLE_TX_PARITY_EN
    logic              par;
`endif

    assign accept = Ce && (state == S_IDLE);

    bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .gclk    (CLK),
        .grst_n  (RST),
        .en      (state != S_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Ce)      state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:
                if (bit_end && bidx == LAST_BIT) begin
`ifdef NIBBLE_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (bit_end) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Parity is taken from the word at accept time, so shifting cannot disturb it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            bidx  <= '0;
`ifdef NIBBLE_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= Din;
            bidx  <= '0;
`ifdef NIBBLE_TX_PARITY_EN
            par   <= ^Din;
`endif
        end else if (state == S_DATA && bit_end) begin
            shreg <= shreg >> 1;
            bidx  <= (bidx == LAST_BIT) ? '0 : bidx + BW'(1);
        end
    end

    // Outputs decode registered state only; async reset forces the line idle at once.
    always_comb begin
        Txd = TXD_IDLE;
        case (state)
            S_START: Txd = TXD_START;
            S_DATA:  Txd = shreg[0];
`ifdef NIBBLE_TX_PARITY_EN
            S_PARITY: Txd = par;
`endif
            default: Txd = TXD_IDLE;
        endcase
    end

    assign Rdy  = (state == S_IDLE);
    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx with a frame-queue reference model.
// Building with NIBBLE_TX_PARITY_EN switches to one clock per bit and runs the parity vectors.
module tb_nibble_serial_tx;

`ifdef NIBBLE_TX_PARITY_EN
    localparam int CPB = 1;
`else
    localparam int CPB = 4;
`endif
    localparam int DW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Ce  = 1'b0;
    logic [DW-1:0] Din = '0;
    logic          Rdy, Txd, Busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic q[$];

    nibble_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Ce   (Ce),
        .Din  (Din),
        .Rdy  (Rdy),
        .Txd  (Txd),
        .Busy (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the whole line waveform of a frame, one entry per clock.
    function automatic void push_frame(input logic [DW-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef NIBBLE_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < CPB; k++) q.push_back(bits[i]);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            if (q.size() > 0) q.delete(0);
            else if (Ce)      push_frame(Din);
        end
    end

    always @(negedge RST) q.delete();

    always @(negedge CLK) begin
        if (RST) begin
            if (q.size() > 0) chk("cycle", {61'd0, Txd, Rdy, Busy}, {61'd0, q[0], 1'b0, 1'b1});
            else              chk("cycle", {61'd0, Txd, Rdy, Busy}, 64'b110);
        end
    end

    task automatic send(input logic [DW-1:0] d);
        @(negedge CLK);
        Ce = 1'b1;
        Din = d;
        @(negedge CLK);
        Ce = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] v, output int rdy_low);
        v = '0;
        rdy_low = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge CLK);
            v = {v[62:0], Txd};
            if (!Rdy) rdy_low++;
        end
    endtask

    initial begin
        logic [63:0] v;
        int rl;

        // Reset with Ce strobes that must be ignored.
        #12 Ce = 1'b1; Din = 4'b0101;
        #20 Ce = 1'b0;
        #18 chk("in_reset", {Txd, Rdy, Busy}, 3'b110);
        #50 RST = 1'b1;
        @(negedge CLK);
        chk("reset_idle", {Txd, Rdy, Busy}, 3'b110);
        repeat (3) @(negedge CLK);

`ifdef NIBBLE_TX_PARITY_EN
        send(4'b0111);
        capture(8, v, rl);
        chk("par_0111", v[7:0], 8'b0111_0111);
        chk("par_0111_rdy", rl, 7);
        send(4'b0011);
        capture(8, v, rl);
        chk("par_0011", v[7:0], 8'b0110_0011);
        chk("par_0011_rdy", rl, 7);
`else
        send(4'b0001);
        capture(25, v, rl);
        chk("single_txd", v[24:0], {4'h0, 4'hF, 12'h000, 4'hF, 1'b1});
        chk("single_rdy_low", rl, 24);

        fork
            send(4'b1000);
            begin
                @(negedge CLK);
                @(negedge CLK);
                capture(25, v, rl);
            end
            begin
                repeat (8) @(negedge CLK);
                Ce = 1'b1;
                Din = 4'b0100;
                repeat (2) @(negedge CLK);
                Ce = 1'b0;
            end
        join
        chk("busy_ignore_txd", v[24:0], {16'h0000, 4'hF, 4'hF, 1'b1});
        repeat (3) @(negedge CLK);
        chk("busy_no_second", Busy, 1'b0);

        @(negedge CLK);
        Ce = 1'b1;
        Din = 4'b0010;
        @(negedge CLK);
        Din = 4'b0100;
        fork
            capture(49, v, rl);
            begin
                repeat (30) @(negedge CLK);
                Ce = 1'b0;
            end
        join
        chk("b2b_txd", v[48:0], {4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1,
                                 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF});
        chk("b2b_rdy_low", rl, 48);
        repeat (3) @(negedge CLK);

        send(4'b1010);
        repeat (13) @(negedge CLK);
        chk("mid_pre_txd", Txd, 1'b0);
        #2 RST = 1'b0;
        #1 chk("mid_async", {Txd, Rdy, Busy}, 3'b110);
        @(negedge CLK);
        RST = 1'b1;
        send(4'b1111);
        capture(25, v, rl);
        chk("after_rst_txd", v[24:0], {4'h0, 16'hFFFF, 4'hF, 1'b1});
        chk("after_rst_rdy", rl, 24);
`endif
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_tx.md
Name: nibble_serial_tx

Overview:
Downstream consumer of the 4-bit clock-enabled data register stage. It takes the registered nibble (Din) when strobed by Ce and transmits it serially as an asynchronous frame: start bit, data LSB-first, stop bit.
- Has a Rdy back-pressure output so the upstream stage knows when a new word is accepted.
- Sits between the register stage and an external serial pin or monitor.

Parameters:
DATA_W, 4, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles per serial bit (>=1); internal counter width = max(1, $clog2(CLKS_PER_BIT))

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-low reset (0 = reset)
Ce  input  1  word-valid strobe from upstream register stage
Din  input  DATA_W  parallel word; sampled only on accept
Rdy  output  1  1 = block idle and will accept on this edge
Txd  output  1  serial line, idle-high
Busy  output  1  1 while a frame is in progress (not IDLE)

Behaviour:
- Reset (RST=0, async, any state): state=IDLE, Txd=1, Rdy=1, Busy=0, shift reg=0, bit/clk counters=0.
  - Reset mid-frame aborts immediately: Txd forced to 1 without waiting for an edge.
- All outputs registered (or decoded from registered state only); no combinational path Ce/Din -> outputs.
- Accept = Ce & Rdy at a rising edge: Din latched into shift reg; state -> START on that edge.
- Ce while Busy: ignored; no queueing. Din changes after accept do not affect the frame.
- FSM states, each bit lasts exactly CLKS_PER_BIT cycles:
  - IDLE: Txd=1, Rdy=1, Busy=0.
  - START: Txd=0.
  - DATA: Txd=shift[0]; shift right at each bit end; after DATA_W bits -> PARITY (if enabled) else STOP.
  - PARITY: see Optional Feature.
  - STOP: Txd=1; after CLKS_PER_BIT cycles -> IDLE.
- Frame length, accept edge to IDLE: (DATA_W+2)*CLKS_PER_BIT cycles, +CLKS_PER_BIT with parity.
- Rdy is high for at least 1 cycle in IDLE between frames.
  - Ce held continuously high gives back-to-back frames separated by exactly 1 idle cycle (Txd=1).
- CLKS_PER_BIT=1: one cycle per bit; counter must not underflow or wrap.
- Bit counter wraps cleanly to 0 on return to IDLE; no stale data from the previous frame.

Optional Feature:
- Macro: NIBBLE_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA; Txd = XOR of the latched word (even parity) for CLKS_PER_BIT cycles; frame grows by one bit.
- Undefined: no PARITY state; DATA goes directly to STOP. The state encoding may still reserve the code.

Decomposition:
- Package nibble_tx_pkg:
  - state typedef (IDLE, START, DATA, PARITY, STOP; 3-bit encoding)
  - TXD_IDLE=1'b1, TXD_START=1'b0 constants
  - function for counter width
- One sub-module, bit_tick_gen:
  - cycle counter 0..CLKS_PER_BIT-1
  - outputs a 1-cycle bit_end pulse; cleared when the FSM is IDLE.
- The FSM and shift register stay in the top module.

Test Plan (CLKS_PER_BIT=4, DATA_W=4 unless noted):
1. Reset: RST=0 at t=0, release after 100 -> Txd=1, Rdy=1, Busy=0. Ce=1 pulses applied during reset cause no activity.
2. Single frame, Din=4'b0001, Ce pulsed 1 cycle:
   - Txd = 0 for 4 cycles, 1 for 4, 0 for 12, 1 for 4.
   - Rdy low for 24 cycles, then high.
3. Ignore-while-busy: accept 4'b1000, then Ce=1 with Din=4'b0100 mid-frame -> only the 4'b1000 frame is sent (data bits 0,0,0,1); no second frame.
4. Back-to-back: Ce held 1, Din=4'b0010 then 4'b0100 -> two frames separated by exactly 1 cycle of Txd=1.
5. Reset mid-frame: assert RST=0 during DATA bit 2 -> Txd=1 asynchronously, state IDLE. After release, a new accept of 4'b1111 is transmitted correctly.
6. NIBBLE_TX_PARITY_EN defined with CLKS_PER_BIT=1:
   - Din=4'b0111 -> Txd sequence 0,1,1,1,0,1,1 (parity=1), 7 cycles.
   - Din=4'b0011 -> parity bit 0.
